// File: rtl/sodor_dmem_pkg.sv
// ============================================================================
//  Module      : sodor_dmem_pkg
//  Description : Shared types and helpers for the sodor data-memory
//                sub-word adapter (memory-type codes, FSM states,
//                alignment check).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sodor_dmem_pkg;

  // Access width/sign codes as driven by the core on req_typ
  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } mem_typ_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } adapter_state_e;

  // True when the request cannot be served: unsupported type or an address
  // that is not naturally aligned for the access width.
  function automatic logic is_misaligned(mem_typ_e typ, logic [1:0] off);
    logic bad;
    case (typ)
      MT_B, MT_BU: bad = 1'b0;
      MT_H, MT_HU: bad = off[0];
      MT_W:        bad = (off != 2'b00);
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sodor_dmem_subword_adapter_lane_unit.sv
// ============================================================================
//  Module      : sodor_dmem_lane_unit
//  Description : Combinational lane logic: extracts and extends sub-word load
//                data, and merges sub-word store data into a read word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sodor_dmem_lane_unit
  import sodor_dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      typ_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword lanes out of the read word
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
  end

  // Load formatting: sign- or zero-extend the selected lane
  always_comb begin
    load_o = '0;
    case (mem_typ_e'(typ_i))
      MT_B:    load_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MT_BU:   load_o = {{(XLEN-8){1'b0}}, byte_sel};
      MT_H:    load_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      MT_HU:   load_o = {{(XLEN-16){1'b0}}, half_sel};
      MT_W:    load_o = rdata_i;
      default: load_o = '0;
    endcase
  end

  // Store merge: overwrite only the addressed lane, keep the rest of the word
  always_comb begin
    merge_o = rdata_i;
    case (mem_typ_e'(typ_i))
      MT_B, MT_BU: merge_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      MT_H, MT_HU: merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default:     merge_o = wdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sodor_dmem_subword_adapter.sv
// ============================================================================
//  Module      : sodor_dmem_subword_adapter
//  Description : Adapts sodor1 byte/half/word data accesses onto a
//                word-granular memory. Sub-word loads are extended, sub-word
//                stores become read-modify-write, bad requests are flagged
//                without touching memory, and lost reads time out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sodor_dmem_subword_adapter
  import sodor_dmem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_data,
  input  logic            req_write_en,
  input  logic [2:0]      req_typ,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_misaligned,
  output logic            resp_timeout,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_data,
  output logic            mem_req_write_en,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data
);

  adapter_state_e  state_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      typ_q;
  logic            we_q;
  logic [TO_W-1:0] wd_q;

  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_misaligned_q;
  logic            resp_timeout_q;
  logic            mem_req_valid_q;
  logic [XLEN-1:0] mem_req_addr_q;
  logic [XLEN-1:0] mem_req_data_q;
  logic            mem_req_write_en_q;

  logic [XLEN-1:0] load_d;
  logic [XLEN-1:0] merge_d;

  // Lane logic works on the live memory response so the formatted/merged
  // word can be registered in the same cycle the response arrives.
  sodor_dmem_lane_unit #(
    .XLEN (XLEN)
  ) u_lane (
    .typ_i   (typ_q),
    .off_i   (addr_q[1:0]),
    .rdata_i (mem_resp_data),
    .wdata_i (wdata_q),
    .load_o  (load_d),
    .merge_o (merge_d)
  );

  // Transaction FSM; every output is registered on entry to its state, and
  // pulse-type outputs fall back to 0 by default each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      addr_q             <= '0;
      wdata_q            <= '0;
      typ_q              <= '0;
      we_q               <= 1'b0;
      wd_q               <= '0;
      req_ready_q        <= 1'b1;
      resp_valid_q       <= 1'b0;
      resp_data_q        <= '0;
      resp_misaligned_q  <= 1'b0;
      resp_timeout_q     <= 1'b0;
      mem_req_valid_q    <= 1'b0;
      mem_req_addr_q     <= '0;
      mem_req_data_q     <= '0;
      mem_req_write_en_q <= 1'b0;
    end else begin
      resp_valid_q       <= 1'b0;
      resp_data_q        <= '0;
      resp_misaligned_q  <= 1'b0;
      resp_timeout_q     <= 1'b0;
      mem_req_valid_q    <= 1'b0;
      mem_req_addr_q     <= '0;
      mem_req_data_q     <= '0;
      mem_req_write_en_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            wdata_q     <= req_data;
            typ_q       <= req_typ;
            we_q        <= req_write_en;
            req_ready_q <= 1'b0;
            if (is_misaligned(mem_typ_e'(req_typ), req_addr[1:0])) begin
              state_q           <= ST_RESP;
              resp_valid_q      <= 1'b1;
              resp_misaligned_q <= 1'b1;
            end else if (req_write_en && (mem_typ_e'(req_typ) == MT_W)) begin
              // Full-word store needs no read of the old contents
              state_q            <= ST_WR_REQ;
              mem_req_valid_q    <= 1'b1;
              mem_req_write_en_q <= 1'b1;
              mem_req_addr_q     <= {req_addr[XLEN-1:2], 2'b00};
              mem_req_data_q     <= req_data;
            end else begin
              state_q         <= ST_RD_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
            end
          end
        end

        ST_RD_REQ: begin
          state_q <= ST_RD_WAIT;
          wd_q    <= '0;
        end

        ST_RD_WAIT: begin
          wd_q <= wd_q + TO_W'(1);
          // A response landing on the final watchdog cycle still wins
          if (mem_resp_valid) begin
            if (we_q) begin
              state_q            <= ST_WR_REQ;
              mem_req_valid_q    <= 1'b1;
              mem_req_write_en_q <= 1'b1;
              mem_req_addr_q     <= {addr_q[XLEN-1:2], 2'b00};
              mem_req_data_q     <= merge_d;
            end else begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= load_d;
            end
          end else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_q        <= ST_RESP;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
          end
        end

        ST_WR_REQ: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_data        = resp_data_q;
  assign resp_misaligned  = resp_misaligned_q;
  assign resp_timeout     = resp_timeout_q;
  assign mem_req_valid    = mem_req_valid_q;
  assign mem_req_addr     = mem_req_addr_q;
  assign mem_req_data     = mem_req_data_q;
  assign mem_req_write_en = mem_req_write_en_q;

endmodule

`default_nettype wire

// File: tb/tb_sodor_dmem_subword_adapter.sv
// ============================================================================
//  Module      : tb_sodor_dmem_subword_adapter
//  Description : Self-checking bench for sodor_dmem_subword_adapter with a
//                word-memory responder and a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sodor_dmem_subword_adapter;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_write_en;
  logic [2:0]  req_typ;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_misaligned;
  logic        resp_timeout;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_req_write_en;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_chk = 0;
  int n_err = 0;

  // Bench state
  logic [31:0] mem [logic [31:0]];
  int          lat = 1;          // memory latency; 0 = never respond
  int          cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0, viol = 0;
  logic [31:0] rd_addr, wr_addr, wr_data;
  int          wr_cyc;
  logic [31:0] got_data;

  sodor_dmem_subword_adapter #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_write_en     (req_write_en),
    .req_typ          (req_typ),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .resp_misaligned  (resp_misaligned),
    .resp_timeout     (resp_timeout),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_req_write_en (mem_req_write_en),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory-side monitor: logs accesses and checks output hygiene
  always @(negedge clk) begin
    if (mem_req_valid) begin
      if (mem_req_addr[1:0] != 2'b00) viol <= viol + 1;
      if (mem_req_write_en) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_req_addr;
        wr_data <= mem_req_data;
        wr_cyc  <= cyc;
      end else begin
        rd_cnt  <= rd_cnt + 1;
        rd_addr <= mem_req_addr;
      end
    end else if (mem_req_write_en) begin
      viol <= viol + 1;
    end
    if (!resp_valid && (resp_data != 0 || resp_misaligned || resp_timeout))
      viol <= viol + 1;
  end

  // Memory responder; also injects stray response pulses while idle
  initial begin
    logic [31:0] a;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !mem_req_write_en && lat > 0) begin
        a = mem_req_addr;
        repeat (lat) @(posedge clk);
        #1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem.exists(a) ? mem[a] : 32'h0;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
      end else if (rst_n && req_ready && $urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
      end
    end
  end

  // One transaction: compute expectations from the access rules, drive it,
  // then compare response, timing and memory traffic.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input logic [2:0] typ, input int l);
    logic [31:0] wa, w, bt, hf, mask, e_data, e_wdata;
    int          off, sh, e_lat, e_rd, e_wr, rd0, wr0, acc, n;
    logic        e_mis, e_to;
    wa  = a & 32'hFFFF_FFFC;
    off = int'(a & 32'h3);
    if (!mem.exists(wa)) mem[wa] = $urandom;
    w   = mem[wa];
    bt  = (w >> (8 * off)) & 32'hFF;
    hf  = (w >> (16 * (off / 2))) & 32'hFFFF;
    e_mis = (typ == 0 || typ == 4 || typ == 7) || ((typ == 2 || typ == 6) && (off % 2 == 1))
            || (typ == 3 && off != 0);
    e_to = 1'b0; e_data = 0; e_wdata = 0; e_rd = 0; e_wr = 0;
    if (e_mis) begin
      e_lat = 1;
    end else if (we && typ == 3) begin
      e_lat = 2; e_wr = 1; e_wdata = d;
    end else if (l == 0) begin
      e_lat = 2 + TO; e_rd = 1; e_to = 1'b1;
    end else if (we) begin
      e_lat = 3 + l; e_rd = 1; e_wr = 1;
      if (typ == 1 || typ == 5) begin
        sh = 8 * off; mask = 32'hFF << sh; e_wdata = (w & ~mask) | ((d & 32'hFF) << sh);
      end else begin
        sh = 16 * (off / 2); mask = 32'hFFFF << sh; e_wdata = (w & ~mask) | ((d & 32'hFFFF) << sh);
      end
    end else begin
      e_lat = 2 + l; e_rd = 1;
      case (typ)
        3'd1:    e_data = (bt >= 128) ? bt + 32'hFFFF_FF00 : bt;
        3'd5:    e_data = bt;
        3'd2:    e_data = (hf >= 32768) ? hf + 32'hFFFF_0000 : hf;
        3'd6:    e_data = hf;
        default: e_data = w;
      endcase
    end

    lat = l;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_addr = a; req_data = d; req_write_en = we; req_typ = typ;
    @(posedge clk);
    #1;
    acc = cyc - 1;
    req_valid = 1'b0; req_addr = $urandom; req_data = $urandom; req_typ = 3'($urandom);
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 4 * TO) begin @(negedge clk); n++; end
    check_val("resp_seen", {31'd0, resp_valid}, 32'd1);
    check_val("resp_lat", cyc - acc, e_lat);
    check_val("resp_data", resp_data, e_data);
    check_val("resp_mis", {31'd0, resp_misaligned}, {31'd0, e_mis});
    check_val("resp_to", {31'd0, resp_timeout}, {31'd0, e_to});
    got_data = resp_data;
    @(negedge clk);
    check_val("ready_back", {31'd0, req_ready}, 32'd1);
    check_val("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check_val("rd_count", rd_cnt - rd0, e_rd);
    check_val("wr_count", wr_cnt - wr0, e_wr);
    if (e_rd == 1) check_val("rd_addr", rd_addr, wa);
    if (e_wr == 1) begin
      check_val("wr_addr", wr_addr, wa);
      check_val("wr_data", wr_data, e_wdata);
      if (e_rd == 0) check_val("wr_cycle", wr_cyc - acc, 1);
      mem[wa] = e_wdata;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0;
    req_write_en = 1'b0; req_typ = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp", {31'd0, resp_valid}, 32'd0);
    check_val("rst_memreq", {31'd0, mem_req_valid}, 32'd0);
    check_val("rst_data", resp_data, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    mem[32'h1000] = 32'h80FF_1234;
    do_txn(32'h1003, 32'h0, 1'b0, 3'd1, 1);
    check_val("tp_lb", got_data, 32'hFFFF_FF80);
    mem[32'h2000] = 32'hBEEF_0001;
    do_txn(32'h2002, 32'h0, 1'b0, 3'd6, 2);
    check_val("tp_lhu", got_data, 32'h0000_BEEF);
    do_txn(32'h2002, 32'h0, 1'b0, 3'd2, 3);
    check_val("tp_lh", got_data, 32'hFFFF_BEEF);
    mem[32'h3000] = 32'h1122_3344;
    do_txn(32'h3001, 32'h0000_005A, 1'b1, 3'd1, 1);
    check_val("tp_sb_mem", mem[32'h3000], 32'h1122_5A44);
    do_txn(32'h4000, 32'hDEAD_BEEF, 1'b1, 3'd3, 1);
    do_txn(32'h5002, 32'h0, 1'b0, 3'd3, 1);
    do_txn(32'h5000, 32'h0, 1'b0, 3'd4, 1);
    do_txn(32'h6000, 32'h0, 1'b0, 3'd2, 0);          // timeout
    do_txn(32'h6000, 32'h0, 1'b0, 3'd2, TO);         // response on last watchdog cycle
    do_txn(32'h6002, 32'h0000_A5A5, 1'b1, 3'd6, TO); // sub-word store, late response

    // Reset while waiting for a read response
    lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h6000; req_write_en = 1'b0; req_typ = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("arst_ready", {31'd0, req_ready}, 32'd1);
    check_val("arst_memreq", {31'd0, mem_req_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (TO + 8) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    check_val("arst_noresp", n, 0);
    check_val("arst_ready2", {31'd0, req_ready}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      int          rl;
      ra = 32'h8000 + $urandom_range(0, 63);
      rl = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
      do_txn(ra, $urandom, 1'($urandom), 3'($urandom), rl);
    end

    check_val("hygiene", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
